// File: rtl/seq_multiplier.sv
// Iterative radix-2 shift-add multiplier producing a full 2N-bit product, signed or unsigned.
// Latency N+1 cycles from accepted start to finish; start is ignored while busy.
module seq_multiplier #(
   parameter int N = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [N-1:0] a_in,
   input  logic [N-1:0] b_in,
   input  logic         signed_mode,
   output logic [N-1:0] out,
   output logic [N-1:0] out_hi,
   output logic         overflow,
   output logic         busy,
   output logic         finish
);

   localparam int CW = $clog2(N);

   typedef enum logic [1:0] {IDLE, CALC, FIN, DONE} state_t;

   state_t         state_q;
   logic [N-1:0]   a_q, b_q;
   logic           sgn_q, neg_q;
   logic [2*N:0]   acc_q;
   logic [CW-1:0]  cnt_q;
   logic [N-1:0]   out_q, hi_q;
   logic           ov_q, busy_q, fin_q;

   logic [N-1:0]   a_mag_d, b_mag_d;
   logic [N:0]     sum_d;
   logic [2*N:0]   acc_d;
   logic [2*N-1:0] prod_d;
   logic           ov_d;

   always_comb begin
      a_mag_d = (signed_mode && a_in[N-1]) ? (~a_in) + N'(1) : a_in;
      b_mag_d = (signed_mode && b_in[N-1]) ? (~b_in) + N'(1) : b_in;
      // Upper half carries into the spare MSB, so the shift never loses a bit.
      sum_d   = acc_q[2*N:N] + {1'b0, a_q};
      acc_d   = b_q[cnt_q] ? ({sum_d, acc_q[N-1:0]} >> 1) : (acc_q >> 1);
      prod_d  = (sgn_q && neg_q) ? (~acc_q[2*N-1:0]) + (2*N)'(1) : acc_q[2*N-1:0];
      if (sgn_q)
         ov_d = (prod_d[2*N-1:N] != {N{prod_d[N-1]}});
      else
         ov_d = |prod_d[2*N-1:N];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sgn_q   <= 1'b0;
         neg_q   <= 1'b0;
         acc_q   <= '0;
         cnt_q   <= '0;
         out_q   <= '0;
         hi_q    <= '0;
         ov_q    <= 1'b0;
         busy_q  <= 1'b0;
         fin_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  a_q     <= a_mag_d;
                  b_q     <= b_mag_d;
                  sgn_q   <= signed_mode;
                  neg_q   <= signed_mode & (a_in[N-1] ^ b_in[N-1]);
                  acc_q   <= '0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  fin_q   <= 1'b0;
                  state_q <= CALC;
               end
            end
            CALC: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(N-1))
                  state_q <= FIN;
            end
            FIN: begin
               out_q   <= prod_d[N-1:0];
               hi_q    <= prod_d[2*N-1:N];
               ov_q    <= ov_d;
               busy_q  <= 1'b0;
               fin_q   <= 1'b1;
               state_q <= DONE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign out      = out_q;
   assign out_hi   = hi_q;
   assign overflow = ov_q;
   assign busy     = busy_q;
   assign finish   = fin_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: N=16 instance for functional/handshake cases, N=8 for the sweep.
module tb_seq_multiplier;

   logic        clk = 1'b0;
   logic        reset;
   logic        start, signed_mode;
   logic [15:0] a_in, b_in;
   logic [15:0] out, out_hi;
   logic        overflow, busy, finish;

   logic        start8;
   logic [7:0]  a8, b8, out8, hi8;
   logic        ov8, busy8, fin8;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seq_multiplier #(.N(16)) u_dut (
      .clk(clk), .reset(reset), .start(start), .a_in(a_in), .b_in(b_in),
      .signed_mode(signed_mode), .out(out), .out_hi(out_hi), .overflow(overflow),
      .busy(busy), .finish(finish)
   );

   seq_multiplier #(.N(8)) u_dut8 (
      .clk(clk), .reset(reset), .start(start8), .a_in(a8), .b_in(b8),
      .signed_mode(1'b0), .out(out8), .out_hi(hi8), .overflow(ov8),
      .busy(busy8), .finish(fin8)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic sm, input logic hold);
      a_in        = a;
      b_in        = b;
      signed_mode = sm;
      start       = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (!hold) start = 1'b0;
   endtask

   task automatic wait_fin(input string tag, input int exp_lat);
      int n;
      n = 0;
      while (finish !== 1'b1 && n < 100) begin
         chk({tag, " busy"}, 32'(busy), 32'd1);
         @(posedge clk);
         @(negedge clk);
         n++;
      end
      chk({tag, " latency"}, n, exp_lat);
      chk({tag, " busy_done"}, 32'(busy), 32'd0);
   endtask

   task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b, input logic sm,
                      input logic [15:0] e_lo, input logic [15:0] e_hi, input logic e_ov);
      launch(a, b, sm, 1'b0);
      wait_fin(tag, 17);
      chk({tag, " out"}, out, e_lo);
      chk({tag, " out_hi"}, out_hi, e_hi);
      chk({tag, " overflow"}, 32'(overflow), 32'(e_ov));
   endtask

   initial begin
      int n8;
      reset = 1'b1; start = 1'b0; signed_mode = 1'b0; a_in = '0; b_in = '0;
      start8 = 1'b0; a8 = '0; b8 = '0;
      repeat (2) @(negedge clk);
      chk("rst out", out, 0);
      chk("rst out_hi", out_hi, 0);
      chk("rst overflow", 32'(overflow), 0);
      chk("rst busy", 32'(busy), 0);
      chk("rst finish", 32'(finish), 0);
      chk("rst finish8", 32'(fin8), 0);
      reset = 1'b0;
      @(negedge clk);

      run("u 2x3",       16'd2,     16'd3,      1'b0, 16'd6,     16'd0,     1'b0);
      run("u 258x258",   16'd258,   16'd258,    1'b0, 16'd1028,  16'd1,     1'b1);
      run("u 32767x2",   16'd32767, 16'd2,      1'b0, 16'd65534, 16'd0,     1'b0);
      run("s -3x5",      16'hFFFD,  16'd5,      1'b1, 16'hFFF1,  16'hFFFF,  1'b0);
      run("s min x -1",  16'h8000,  16'hFFFF,   1'b1, 16'h8000,  16'h0000,  1'b1);
      run("s 0x123",     16'd0,     16'h0123,   1'b1, 16'd0,     16'd0,     1'b0);
      run("s 5x-7",      16'd5,     16'hFFF9,   1'b1, 16'hFFDD,  16'hFFFF,  1'b0);

      // start pulsed mid-calculation with different operands must be ignored
      launch(16'd7, 16'd9, 1'b0, 1'b0);
      repeat (5) @(negedge clk);
      a_in = 16'd100; b_in = 16'd100; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_fin("ign", 11);
      chk("ign out", out, 63);
      repeat (3) @(negedge clk);
      chk("ign no restart busy", 32'(busy), 0);
      chk("ign finish held", 32'(finish), 1);
      chk("ign out held", out, 63);

      // start held: operand change after acceptance ignored, re-issue on return to DONE
      launch(16'd4, 16'd5, 1'b0, 1'b1);
      a_in = 16'd6; b_in = 16'd7;
      chk("b2b old result held", out, 63);
      wait_fin("b2b first", 17);
      chk("b2b first out", out, 20);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      chk("b2b reissue busy", 32'(busy), 1);
      chk("b2b reissue finish", 32'(finish), 0);
      chk("b2b held out", out, 20);
      wait_fin("b2b second", 17);
      chk("b2b second out", out, 42);

      // reset during CALC clears everything at once
      launch(16'd1000, 16'd1000, 1'b0, 1'b0);
      repeat (7) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("midrst out", out, 0);
      chk("midrst out_hi", out_hi, 0);
      chk("midrst overflow", 32'(overflow), 0);
      chk("midrst busy", 32'(busy), 0);
      chk("midrst finish", 32'(finish), 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("midrst no result", 32'(finish), 0);
      run("post-rst 10x10", 16'd10, 16'd10, 1'b0, 16'd100, 16'd0, 1'b0);

      // N=8 sweep instance
      a8 = 8'd255; b8 = 8'd255; start8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start8 = 1'b0;
      chk("n8 busy", 32'(busy8), 1);
      n8 = 0;
      while (fin8 !== 1'b1 && n8 < 100) begin
         @(posedge clk);
         @(negedge clk);
         n8++;
      end
      chk("n8 latency", n8, 9);
      chk("n8 out", out8, 8'h01);
      chk("n8 out_hi", hi8, 8'hFE);
      chk("n8 overflow", 32'(ov8), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Parametrised iterative shift-add multiplier with a start/finish handshake, replacing the single-cycle 16-bit ALU multiplier. It produces the full 2N-bit product (low and high halves), supports signed and unsigned modes, and flags results that do not fit in N bits. It sits in the ALU multiplier slot. The control unit pulses `start`, then waits for `finish`.

## Interface
- `N`, default 16: operand width and width of each result half; legal values are N >= 2.
- `clk`  in  1  clock; all state changes occur on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a new multiply; sampled on the rising edge.
- `a_in`  in  N  multiplicand; captured when `start` is accepted.
- `b_in`  in  N  multiplier; captured when `start` is accepted.
- `signed_mode`  in  1  selects the operand mode, captured with the operands: 1 = two's-complement operands, 0 = unsigned operands.
- `out`  out  N  low N bits of the product (truncated result).
- `out_hi`  out  N  high N bits of the product.
- `overflow`  out  1  high when the product is not representable in N bits in the captured mode.
- `busy`  out  1  high while a multiply is in progress.
- `finish`  out  1  high while a valid result is held.

## Operation
- FSM states are IDLE, CALC, FIN and DONE.
- **IDLE or DONE with `start`=1:**
  - Latch `a_in`, `b_in` and `signed_mode`.
  - Clear the accumulator and the iteration counter.
  - In signed mode, store the operand magnitudes and record `neg` = sign(a) XOR sign(b).
  - Next state is CALC; `finish` drops to 0 and `busy` rises to 1.
- **CALC:** runs exactly N iterations, radix-2, LSB first.
  - Add the multiplicand to the upper half of the 2N+1-bit accumulator if the current multiplier bit is 1.
  - Then shift the accumulator right by 1.
  - After iteration N-1, go to FIN.
- **FIN:**
  - Apply two's-complement negation to the 2N-bit product if signed mode and `neg` are both set.
  - Register `out`, `out_hi` and `overflow`.
  - Next state is DONE.
- **DONE:**
  - `finish`=1 and `busy`=0.
  - Results are held stable until the next accepted `start` or `reset`.
- **`start` while in CALC or FIN:** ignored; the operation in progress continues unaffected.
- **Operand changes after acceptance:** ignored.
- **Overflow rule, unsigned mode:** `overflow` = (`out_hi` != 0).
- **Overflow rule, signed mode:** `overflow` = 1 unless every bit of `out_hi` equals `out[N-1]`.
- **Zero operands:** follow the normal path with the same latency; the product is 0 and `overflow`=0.
- **Result registers:** `out`, `out_hi` and `overflow` change only on the FIN→DONE edge.
  - When a new operation starts, they keep the previous result until the new FIN.

## Timing
- **Reset values:**
  - State is IDLE.
  - `out`=0, `out_hi`=0, `overflow`=0, `busy`=0, `finish`=0.
  - Accumulator and counter are 0.
- **Reset mid-operation:** asserting `reset` during CALC or FIN aborts the operation immediately and produces no result. The first `start` after reset deasserts behaves normally.
- **Acceptance:** let edge E0 be the edge at which `start` is accepted.
  - `busy`=1 is visible after E0.
  - CALC iterations occur on edges E1..EN.
  - FIN is on edge EN+1.
  - `finish`=1 and valid results are visible after edge EN+1.
  - Total latency is N+1 cycles (17 for N=16).
- **Back-to-back:** `start` held high in DONE is accepted on the next edge, giving a throughput of one result per N+2 cycles.
- **`start` held high continuously:** operations are re-issued whenever the block returns to DONE.
- **Output timing:** all outputs are registered; there is no combinational path from any input to any output.

## Test plan
- **Unsigned basic:** N=16, unsigned, 2×3 → `out`=6, `out_hi`=0, `overflow`=0. `finish` rises exactly 17 edges after acceptance, and `busy` is high for the 17 cycles in between.
- **Unsigned wrap-around:** 258×258 → `out`=1028, `out_hi`=1, `overflow`=1. Also 32767×2 → `out`=65534, `out_hi`=0, `overflow`=0.
- **Signed:**
  - −3×5 → `out`=0xFFF1, `out_hi`=0xFFFF, `overflow`=0.
  - −32768×−1 → `out`=0x8000, `out_hi`=0x0000, `overflow`=1.
  - 0×123 → all result outputs 0.
- **Handshake:** pulse `start` during CALC with different operands → the original result is unchanged and there is no extra `finish`. Holding `start` in DONE starts a new operation on the next edge, and the old result is held until the new FIN.
- **Reset mid-operation:** assert `reset` at iteration 7 → all outputs read 0 immediately. The subsequent 10×10 gives `out`=100 after 17 cycles.
- **Parameter sweep:** N=8, unsigned, 255×255 → `out`=0x01, `out_hi`=0xFE, `overflow`=1, latency 9 cycles.
